// File: rtl/vga_pkg.sv
// vga_pkg: shared types, default timing constants and pattern helpers for the
// VGA source scheduler and its frame-tick detector.
package vga_pkg;

   localparam int unsigned H_TOTAL_DEF     = 800;
   localparam int unsigned V_TOTAL_DEF     = 525;
   localparam int unsigned HOLD_FRAMES_DEF = 60;

   localparam int unsigned CNT_W   = 10;
   localparam int unsigned SW_W    = 10;
   localparam int unsigned PAT_W   = 3;
   localparam int unsigned FRAME_W = 16;

   // Pattern index; the auto schedule steps through these in order and wraps.
   typedef enum logic [1:0] {
      PAT_RED   = 2'd0,
      PAT_CHECK = 2'd1,
      PAT_GRAD  = 2'd2,
      PAT_WHITE = 2'd3
   } pattern_e;

   // Display ownership between the test pattern generator and the renderer.
   typedef enum logic [1:0] {
      TP_OWN     = 2'd0,
      GRANT_PEND = 2'd1,
      RND_OWN    = 2'd2,
      REL_PEND   = 2'd3
   } own_state_e;

   // Pattern index to the generator's one-hot select (WHITE selects nothing).
   function automatic logic [PAT_W-1:0] pattern_onehot(input pattern_e pat);
      logic [PAT_W-1:0] sel;
      case (pat)
         PAT_RED:   sel = 3'b001;
         PAT_CHECK: sel = 3'b010;
         PAT_GRAD:  sel = 3'b100;
         default:   sel = 3'b000;
      endcase
      return sel;
   endfunction

   // Manual switch decode with the generator's priority: bit0 > bit1 > bit2.
   function automatic pattern_e pattern_from_sw(input logic [PAT_W-1:0] sw);
      pattern_e pat;
      if (sw[0]) begin
         pat = PAT_RED;
      end else if (sw[1]) begin
         pat = PAT_CHECK;
      end else if (sw[2]) begin
         pat = PAT_GRAD;
      end else begin
         pat = PAT_WHITE;
      end
      return pat;
   endfunction

endpackage

// File: rtl/vga_frame_tick.sv
// vga_frame_tick: flags the last pixel of the last line of a frame.
// Ports:
//   hcount       in  CNT_W  current pixel column
//   vcount       in  CNT_W  current line
//   frame_tick_c out 1      high for the single cycle at (H_TOTAL-1, V_TOTAL-1)
module vga_frame_tick
   import vga_pkg::*;
#(
   parameter int unsigned H_TOTAL = H_TOTAL_DEF,
   parameter int unsigned V_TOTAL = V_TOTAL_DEF
) (
   input  logic [CNT_W-1:0] hcount,
   input  logic [CNT_W-1:0] vcount,
   output logic             frame_tick_c
);

   localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

   assign frame_tick_c = (hcount == H_LAST) && (vcount == V_LAST);

endmodule

// File: rtl/vga_source_scheduler.sv
// vga_source_scheduler: frame-synchronous pattern schedule and display
// ownership arbiter. Every visible change is committed on the frame-tick edge
// so it first appears at hcount = vcount = 0.
// Ports:
//   vga_clk      in  1   pixel clock
//   reset        in  1   synchronous, active-high
//   hcount       in  10  pixel column from the timing generator
//   vcount       in  10  line from the timing generator
//   SW           in  10  SW[2:0] manual pattern, SW[9] auto enable
//   next_req     in  1   pulse: advance pattern at next frame (auto only)
//   render_req   in  1   level: renderer wants the display
//   render_grant out 1   renderer owns the display
//   src_sel      out 1   pixel mux select, 1 = renderer
//   pattern_sel  out 3   one-hot pattern generator select
//   frame_cnt    out 16  frames since reset, wrapping
module vga_source_scheduler
   import vga_pkg::*;
#(
   parameter int unsigned H_TOTAL     = H_TOTAL_DEF,
   parameter int unsigned V_TOTAL     = V_TOTAL_DEF,
   parameter int unsigned HOLD_FRAMES = HOLD_FRAMES_DEF
) (
   input  logic               vga_clk,
   input  logic               reset,
   input  logic [CNT_W-1:0]   hcount,
   input  logic [CNT_W-1:0]   vcount,
   input  logic [SW_W-1:0]    SW,
   input  logic               next_req,
   input  logic               render_req,
   output logic               render_grant,
   output logic               src_sel,
   output logic [PAT_W-1:0]   pattern_sel,
   output logic [FRAME_W-1:0] frame_cnt
);

   localparam int unsigned     HOLD_W    = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);

   logic               frame_tick_c;
   logic               auto_en_c;
   logic               unused_sw_c;

   logic [HOLD_W-1:0]  hold_q, hold_d;
   pattern_e           idx_q, idx_d;
   logic               adv_pend_q, adv_pend_d;
   logic [PAT_W-1:0]   pattern_sel_q, pattern_sel_d;
   logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
   own_state_e         own_q, own_d;
   logic               render_grant_q, render_grant_d;
   logic               src_sel_q, src_sel_d;

   vga_frame_tick #(
      .H_TOTAL (H_TOTAL),
      .V_TOTAL (V_TOTAL)
   ) u_frame_tick (
      .hcount       (hcount),
      .vcount       (vcount),
      .frame_tick_c (frame_tick_c)
   );

   assign auto_en_c   = SW[SW_W-1];
   assign unused_sw_c = ^SW[SW_W-2:PAT_W];

   // Pattern schedule and frame counter.
   always_comb begin
      hold_d        = hold_q;
      idx_d         = idx_q;
      adv_pend_d    = adv_pend_q;
      pattern_sel_d = pattern_sel_q;
      frame_cnt_d   = frame_cnt_q;

      if (frame_tick_c) begin
         frame_cnt_d = frame_cnt_q + FRAME_W'(1);
         if (!auto_en_c) begin
            // Loading the index from SW lets a return to auto resume here.
            idx_d      = pattern_from_sw(SW[PAT_W-1:0]);
            hold_d     = '0;
            adv_pend_d = 1'b0;
         end else begin
            // A request landing on the tick itself is held for the next tick.
            adv_pend_d = next_req;
            // Pending request and hold expiry merge into one single step.
            if (adv_pend_q || (hold_q == HOLD_LAST)) begin
               idx_d  = pattern_e'(2'(idx_q + 2'd1));
               hold_d = '0;
            end else begin
               hold_d = hold_q + HOLD_W'(1);
            end
         end
         pattern_sel_d = pattern_onehot(idx_d);
      end else if (auto_en_c && next_req) begin
         adv_pend_d = 1'b1;
      end
   end

   // Ownership FSM: grant and release only ever commit on a frame tick.
   always_comb begin
      own_d          = own_q;
      render_grant_d = render_grant_q;
      src_sel_d      = src_sel_q;

      case (own_q)
         TP_OWN: begin
            if (render_req) own_d = GRANT_PEND;
         end
         GRANT_PEND: begin
            if (!render_req) begin
               own_d = TP_OWN;
            end else if (frame_tick_c) begin
               own_d = RND_OWN;
            end
         end
         RND_OWN: begin
            if (!render_req) own_d = REL_PEND;
         end
         REL_PEND: begin
            // Re-assertion wins over the tick, so the renderer keeps the display.
            if (render_req) begin
               own_d = RND_OWN;
            end else if (frame_tick_c) begin
               own_d = TP_OWN;
            end
         end
         default: own_d = TP_OWN;
      endcase

      render_grant_d = (own_d == RND_OWN) || (own_d == REL_PEND);
      src_sel_d      = render_grant_d;
   end

   always_ff @(posedge vga_clk) begin
      if (reset) begin
         hold_q         <= '0;
         idx_q          <= PAT_RED;
         adv_pend_q     <= 1'b0;
         pattern_sel_q  <= 3'b001;
         frame_cnt_q    <= '0;
         own_q          <= TP_OWN;
         render_grant_q <= 1'b0;
         src_sel_q      <= 1'b0;
      end else begin
         hold_q         <= hold_d;
         idx_q          <= idx_d;
         adv_pend_q     <= adv_pend_d;
         pattern_sel_q  <= pattern_sel_d;
         frame_cnt_q    <= frame_cnt_d;
         own_q          <= own_d;
         render_grant_q <= render_grant_d;
         src_sel_q      <= src_sel_d;
      end
   end

   assign render_grant = render_grant_q;
   assign src_sel      = src_sel_q;
   assign pattern_sel  = pattern_sel_q;
   assign frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_vga_source_scheduler.sv
// Bench for vga_source_scheduler with an 8x4 frame and a two-frame hold.
module tb_vga_source_scheduler;

   localparam int H_T  = 8;
   localparam int V_T  = 4;
   localparam int HOLD = 2;

   logic        vga_clk = 1'b0;
   logic        reset;
   logic [9:0]  hcount;
   logic [9:0]  vcount;
   logic [9:0]  SW;
   logic        next_req;
   logic        render_req;
   logic        render_grant;
   logic        src_sel;
   logic [2:0]  pattern_sel;
   logic [15:0] frame_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   // Bench-side timing position and a mode that parks it on the last pixel.
   int h = 0;
   int v = 0;
   bit tick_mode = 1'b0;

   // Reference model state.
   int m_idx = 0;
   int m_hold = 0;
   bit m_pend = 1'b0;
   bit m_grant = 1'b0;
   bit m_req_prev = 1'b0;
   int m_frames = 0;
   logic [2:0] onehot_tbl [4] = '{3'b001, 3'b010, 3'b100, 3'b000};

   vga_source_scheduler #(
      .H_TOTAL     (H_T),
      .V_TOTAL     (V_T),
      .HOLD_FRAMES (HOLD)
   ) dut (
      .vga_clk      (vga_clk),
      .reset        (reset),
      .hcount       (hcount),
      .vcount       (vcount),
      .SW           (SW),
      .next_req     (next_req),
      .render_req   (render_req),
      .render_grant (render_grant),
      .src_sel      (src_sel),
      .pattern_sel  (pattern_sel),
      .frame_cnt    (frame_cnt)
   );

   always #5 vga_clk = ~vga_clk;

   function automatic int prio_idx(input logic [2:0] s);
      if (s[0]) return 0;
      if (s[1]) return 1;
      if (s[2]) return 2;
      return 3;
   endfunction

   // One clock: drive position, clock, update the model from what was driven.
   // Ownership rule: at a frame end the grant flips only when render_req was
   // sampled the same way on that cycle and the cycle before.
   task automatic step();
      int dh;
      int dv;
      bit tick;
      dh = tick_mode ? H_T - 1 : h;
      dv = tick_mode ? V_T - 1 : v;
      hcount = 10'(dh);
      vcount = 10'(dv);
      @(posedge vga_clk);
      tick = (dh == H_T - 1) && (dv == V_T - 1);
      if (reset) begin
         m_idx = 0; m_hold = 0; m_pend = 1'b0; m_grant = 1'b0;
         m_req_prev = 1'b0; m_frames = 0;
      end else begin
         if (tick) begin
            m_frames = (m_frames + 1) % 65536;
            if (!SW[9]) begin
               m_idx = prio_idx(SW[2:0]); m_hold = 0; m_pend = 1'b0;
            end else begin
               if (m_pend || m_hold == HOLD - 1) begin
                  m_idx = (m_idx + 1) % 4; m_hold = 0;
               end else begin
                  m_hold = m_hold + 1;
               end
               m_pend = next_req;
            end
            if (!m_grant && m_req_prev && render_req) m_grant = 1'b1;
            else if (m_grant && !m_req_prev && !render_req) m_grant = 1'b0;
         end else if (SW[9] && next_req) begin
            m_pend = 1'b1;
         end
         m_req_prev = render_req;
      end
      #1;
      if (!tick_mode) begin
         h = h + 1;
         if (h == H_T) begin h = 0; v = (v + 1) % V_T; end
      end
   endtask

   task automatic run_steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic test_reset();
      n_checks++; if (render_grant !== 1'b0) begin n_fail++; $display("FAIL rst_grant: got %b expected 0", render_grant); end
      n_checks++; if (src_sel !== 1'b0) begin n_fail++; $display("FAIL rst_src_sel: got %b expected 0", src_sel); end
      n_checks++; if (pattern_sel !== 3'b001) begin n_fail++; $display("FAIL rst_pattern: got %b expected 001", pattern_sel); end
      n_checks++; if (frame_cnt !== 16'h0000) begin n_fail++; $display("FAIL rst_frame_cnt: got %h expected 0000", frame_cnt); end
   endtask

   task automatic test_auto_cycle();
      logic [2:0] exp_seq [8] = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100, 3'b000, 3'b000};
      while (!(h == 0 && v == 0)) step();
      reset = 1'b0;
      SW = 10'h200;
      for (int f = 0; f < 8; f++) begin
         n_checks++; if (pattern_sel !== exp_seq[f]) begin n_fail++; $display("FAIL auto_frame%0d: got %b expected %b", f, pattern_sel, exp_seq[f]); end
         n_checks++; if (pattern_sel !== onehot_tbl[m_idx]) begin n_fail++; $display("FAIL auto_model%0d: got %b expected %b", f, pattern_sel, onehot_tbl[m_idx]); end
         run_steps(31);
         n_checks++; if (pattern_sel !== exp_seq[f]) begin n_fail++; $display("FAIL auto_early%0d: got %b expected %b", f, pattern_sel, exp_seq[f]); end
         step();
      end
      n_checks++; if (frame_cnt !== 16'd8) begin n_fail++; $display("FAIL auto_frames: got %0d expected 8", frame_cnt); end
   endtask

   task automatic test_next_req();
      // Next request mid-frame: one step, hold restarts.
      run_steps(11); next_req = 1'b1; step(); next_req = 1'b0; run_steps(20);
      n_checks++; if (pattern_sel !== 3'b010) begin n_fail++; $display("FAIL next_mid: got %b expected 010", pattern_sel); end
      run_steps(32);
      n_checks++; if (pattern_sel !== 3'b010) begin n_fail++; $display("FAIL next_hold_clr: got %b expected 010", pattern_sel); end
      // Request coinciding with hold expiry: still a single step.
      run_steps(11); next_req = 1'b1; step(); next_req = 1'b0; run_steps(20);
      n_checks++; if (pattern_sel !== 3'b100) begin n_fail++; $display("FAIL next_single_step: got %b expected 100", pattern_sel); end
      // Request on the tick cycle: deferred one frame.
      run_steps(31); next_req = 1'b1; step(); next_req = 1'b0;
      n_checks++; if (pattern_sel !== 3'b100) begin n_fail++; $display("FAIL next_on_tick: got %b expected 100", pattern_sel); end
      run_steps(32);
      n_checks++; if (pattern_sel !== 3'b000) begin n_fail++; $display("FAIL next_deferred: got %b expected 000", pattern_sel); end
      n_checks++; if (pattern_sel !== onehot_tbl[m_idx]) begin n_fail++; $display("FAIL next_model: got %b expected %b", pattern_sel, onehot_tbl[m_idx]); end
   endtask

   task automatic test_render();
      run_steps(10); render_req = 1'b1; run_steps(21);
      n_checks++; if (render_grant !== 1'b0) begin n_fail++; $display("FAIL grant_early: got %b expected 0", render_grant); end
      step();
      n_checks++; if (render_grant !== 1'b1) begin n_fail++; $display("FAIL grant_at_tick: got %b expected 1", render_grant); end
      n_checks++; if (src_sel !== 1'b1) begin n_fail++; $display("FAIL src_at_tick: got %b expected 1", src_sel); end
      run_steps(3); render_req = 1'b0; run_steps(28);
      n_checks++; if (render_grant !== 1'b1) begin n_fail++; $display("FAIL release_early: got %b expected 1", render_grant); end
      step();
      n_checks++; if (render_grant !== 1'b0) begin n_fail++; $display("FAIL release_at_tick: got %b expected 0", render_grant); end
      n_checks++; if (src_sel !== 1'b0) begin n_fail++; $display("FAIL release_src: got %b expected 0", src_sel); end
      // Request withdrawn before the tick: no grant.
      run_steps(5); render_req = 1'b1; run_steps(3); render_req = 1'b0; run_steps(24);
      n_checks++; if (render_grant !== 1'b0) begin n_fail++; $display("FAIL withdrawn: got %b expected 0", render_grant); end
      // Re-assert during release pending: grant is kept.
      render_req = 1'b1; run_steps(32);
      n_checks++; if (render_grant !== 1'b1) begin n_fail++; $display("FAIL regrant: got %b expected 1", render_grant); end
      run_steps(5); render_req = 1'b0; run_steps(4); render_req = 1'b1; run_steps(23);
      n_checks++; if (render_grant !== 1'b1) begin n_fail++; $display("FAIL reassert_keep: got %b expected 1", render_grant); end
      n_checks++; if (pattern_sel !== onehot_tbl[m_idx]) begin n_fail++; $display("FAIL render_sched: got %b expected %b", pattern_sel, onehot_tbl[m_idx]); end
   endtask

   task automatic test_reset_mid();
      run_steps(12);
      next_req = 1'b1; reset = 1'b1; step(); reset = 1'b0; next_req = 1'b0;
      n_checks++; if (render_grant !== 1'b0) begin n_fail++; $display("FAIL midrst_grant: got %b expected 0", render_grant); end
      n_checks++; if (src_sel !== 1'b0) begin n_fail++; $display("FAIL midrst_src: got %b expected 0", src_sel); end
      n_checks++; if (pattern_sel !== 3'b001) begin n_fail++; $display("FAIL midrst_pattern: got %b expected 001", pattern_sel); end
      n_checks++; if (frame_cnt !== 16'h0000) begin n_fail++; $display("FAIL midrst_frame_cnt: got %h expected 0000", frame_cnt); end
      render_req = 1'b0; run_steps(19);
      n_checks++; if (pattern_sel !== onehot_tbl[m_idx]) begin n_fail++; $display("FAIL midrst_after: got %b expected %b", pattern_sel, onehot_tbl[m_idx]); end
   endtask

   task automatic test_manual();
      int k;
      logic [2:0] s;
      SW = 10'h001; run_steps(32);
      n_checks++; if (pattern_sel !== 3'b001) begin n_fail++; $display("FAIL man_red: got %b expected 001", pattern_sel); end
      run_steps(10); SW = 10'h006; run_steps(21);
      n_checks++; if (pattern_sel !== 3'b001) begin n_fail++; $display("FAIL man_early: got %b expected 001", pattern_sel); end
      step();
      n_checks++; if (pattern_sel !== 3'b010) begin n_fail++; $display("FAIL man_110: got %b expected 010", pattern_sel); end
      for (int f = 0; f < 4; f++) begin
         k = int'($urandom_range(1, 30));
         s = 3'($urandom_range(0, 7));
         run_steps(k); SW = {7'b0, s}; run_steps(32 - k);
         n_checks++; if (pattern_sel !== onehot_tbl[prio_idx(s)]) begin n_fail++; $display("FAIL man_rand sw=%b: got %b expected %b", s, pattern_sel, onehot_tbl[prio_idx(s)]); end
      end
      // Back to auto: schedule resumes from the manual index.
      SW = 10'h200;
      for (int f = 0; f < 3; f++) begin
         run_steps(32);
         n_checks++; if (pattern_sel !== onehot_tbl[m_idx]) begin n_fail++; $display("FAIL resume%0d: got %b expected %b", f, pattern_sel, onehot_tbl[m_idx]); end
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 40 * 32; c++) begin
         next_req = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 9) == 0) render_req = ~render_req;
         if ($urandom_range(0, 63) == 0) SW = {($urandom_range(0, 3) != 0), 6'b0, 3'($urandom_range(0, 7))};
         step();
         n_checks++; if (pattern_sel !== onehot_tbl[m_idx]) begin n_fail++; $display("FAIL rnd_pattern c=%0d: got %b expected %b", c, pattern_sel, onehot_tbl[m_idx]); end
         n_checks++; if (render_grant !== m_grant) begin n_fail++; $display("FAIL rnd_grant c=%0d: got %b expected %b", c, render_grant, m_grant); end
         n_checks++; if (src_sel !== m_grant) begin n_fail++; $display("FAIL rnd_src c=%0d: got %b expected %b", c, src_sel, m_grant); end
         n_checks++; if (frame_cnt !== 16'(m_frames)) begin n_fail++; $display("FAIL rnd_frames c=%0d: got %0d expected %0d", c, frame_cnt, m_frames); end
      end
      next_req = 1'b0;
   endtask

   task automatic test_wrap();
      int guard;
      SW = 10'h200; render_req = 1'b1; next_req = 1'b0; tick_mode = 1'b1;
      guard = 0;
      while (m_frames != 65535 && guard < 70000) begin step(); guard++; end
      if (guard >= 70000) begin
         n_checks++; n_fail++; $display("FAIL wrap_budget: got %0d frames expected 65535", m_frames);
      end
      n_checks++; if (frame_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_pre: got %h expected ffff", frame_cnt); end
      step();
      n_checks++; if (frame_cnt !== 16'h0000) begin n_fail++; $display("FAIL wrap_zero: got %h expected 0000", frame_cnt); end
      n_checks++; if (pattern_sel !== onehot_tbl[m_idx]) begin n_fail++; $display("FAIL wrap_pattern: got %b expected %b", pattern_sel, onehot_tbl[m_idx]); end
      n_checks++; if (render_grant !== 1'b1) begin n_fail++; $display("FAIL wrap_grant: got %b expected 1", render_grant); end
      n_checks++; if (src_sel !== 1'b1) begin n_fail++; $display("FAIL wrap_src: got %b expected 1", src_sel); end
      tick_mode = 1'b0;
   endtask

   initial begin
      reset = 1'b1; SW = 10'h000; next_req = 1'b0; render_req = 1'b0;
      hcount = '0; vcount = '0;
      #1;
      step(); step();
      test_reset();
      test_auto_cycle();
      test_next_req();
      test_render();
      test_reset_mid();
      test_manual();
      test_random();
      test_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
